// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg: shared defaults, drain FSM state type and the issue-credit helper
// for the FIFO stream reader.
package fifo_rd_pkg;

    localparam int DATA_W_DEF    = 8;
    localparam int CNT_W_DEF     = 7;
    localparam int WATERMARK_DEF = 16;

    // Skid buffer capacity; reads are throttled so it can never overflow.
    localparam logic [1:0] SKID_FULL = 2'd2;

    typedef enum logic {
        WAIT  = 1'b0,
        DRAIN = 1'b1
    } rd_state_t;

    // A new read may go out only if every word already buffered or in flight,
    // minus the one leaving this cycle, still leaves a free skid slot.
    function automatic logic can_issue(input logic [1:0] occ,
                                       input logic       inflight,
                                       input logic       pop);
        logic [2:0] pending;
        pending = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
        return pending < {1'b0, SKID_FULL};
    endfunction

endpackage

// File: rtl/fifo_rd_skid.sv
// fifo_rd_skid: two-entry in-order skid buffer feeding the output stream.
// The head entry drives the stream; the tail only fills while the head stalls.
module fifo_rd_skid
    import fifo_rd_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output logic [1:0]        o_occ
);

    logic [DATA_W-1:0] r_head;
    logic [DATA_W-1:0] r_tail;
    logic [1:0]        r_occ;
    logic              w_pop;
    logic              w_push;

    // Pops of an empty buffer and pushes into a full, non-draining buffer are
    // dropped; the issue logic upstream never requests either.
    assign w_pop  = i_pop && (r_occ != 2'd0);
    assign w_push = i_push && ((r_occ != SKID_FULL) || w_pop);

    // Head/tail shuffle and occupancy; push+pop on a full buffer stays full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) r_head <= i_data;
                    else               r_tail <= i_data;
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_head <= r_tail;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == SKID_FULL) begin
                        r_head <= r_tail;
                        r_tail <= i_data;
                    end else begin
                        r_head <= i_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_data = r_head;
    assign o_occ  = r_occ;

endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: pulls words out of a registered-count FIFO (one-cycle
// read latency) and presents them as a valid/ready stream at 1 word/cycle.
// Optional FIFO_RD_WATERMARK_EN: hold reads in WAIT until the FIFO reaches
// WATERMARK words or a flush is requested, then DRAIN until empty.
module fifo_stream_reader
    import fifo_rd_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int CNT_W     = CNT_W_DEF,
    parameter int WATERMARK = WATERMARK_DEF
) (
    input  logic              clk,
    input  logic              rst,
    output logic              fifo_read_en,
    input  logic [DATA_W-1:0] fifo_data,
    input  logic [CNT_W-1:0]  fifo_count,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    input  logic              flush,
    output logic [15:0]       words_read
);

    logic        r_run;
    logic        r_inflight;
    logic [15:0] r_words;
    logic [1:0]  w_occ;
    logic        w_pop;
    logic        w_gate;
    logic        w_rd;

    assign m_valid = (w_occ != 2'd0);
    assign w_pop   = m_valid && m_ready;

    // Reads key off fifo_count only; the FIFO's flags lag the count by a cycle.
    assign w_rd = r_run && w_gate && (fifo_count != '0)
                  && can_issue(w_occ, r_inflight, w_pop);
    assign fifo_read_en = w_rd;

    // Hold off reads until the first edge after reset is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_run <= 1'b0;
        else     r_run <= 1'b1;
    end

    // A read issued this cycle returns data next cycle; capture it then.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_inflight <= 1'b0;
        else     r_inflight <= w_rd;
    end

    // Completed output handshakes, free-running 16-bit wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        r_words <= 16'd0;
        else if (w_pop) r_words <= r_words + 16'd1;
    end

    assign words_read = r_words;

    fifo_rd_skid #(
        .DATA_W (DATA_W)
    ) u_skid (
        .clk    (clk),
        .rst    (rst),
        .i_push (r_inflight),
        .i_data (fifo_data),
        .i_pop  (w_pop),
        .o_data (m_data),
        .o_occ  (w_occ)
    );

`ifdef FIFO_RD_WATERMARK_EN
    rd_state_t r_state;
    logic      r_flush;

    assign w_gate = (r_state == DRAIN);

    // WAIT/DRAIN control; a flush pulse is remembered until the drain it
    // triggers completes. A flush arriving on the exit cycle re-arms the latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= WAIT;
            r_flush <= 1'b0;
        end else begin
            case (r_state)
                WAIT: begin
                    if ((int'(fifo_count) >= WATERMARK) || r_flush)
                        r_state <= DRAIN;
                    if (flush)
                        r_flush <= 1'b1;
                end
                DRAIN: begin
                    if ((fifo_count == '0) && !r_inflight) begin
                        r_state <= WAIT;
                        r_flush <= flush;
                    end else if (flush) begin
                        r_flush <= 1'b1;
                    end
                end
                default: r_state <= WAIT;
            endcase
        end
    end
`else
    // Always draining: flush and WATERMARK have no effect in this build.
    logic w_unused_cfg;

    assign w_gate       = 1'b1;
    assign w_unused_cfg = flush ^ (int'(fifo_count) >= WATERMARK);
`endif

endmodule
